// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, fixed-point format, complex bin type
// and a bit-reversal helper used by the output index mapper.
package fft_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_WIDTH = 16;
  localparam int unsigned FFT_FRAC  = 7;

  // Upper half real, lower half imag, matching the flattened bin packing.
  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } complex_t;

  // Reverse the low `width` bits of idx; bits above width come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = idx;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// Purely combinational W-bit index reversal, used to read bit-reversed storage
// in natural frequency order.
module fft_bitrev_index
  import fft_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] idx,
  output logic [W-1:0] rev
);

  // Reverse the counter bits.
  always_comb begin
    rev = W'(bitrev(32'(idx), W));
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Captures one frame of N_POINTS complex bins in a single cycle and streams
// them out one bin per beat over valid/ready. A new frame may load on the
// cycle the last beat is accepted, so frames run back-to-back with no bubble.
// Optional build macro: BIT_REVERSE_EN reads the buffer in bit-reversed order
// while out_index reports the natural bin number.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = FFT_N,
  parameter int unsigned WIDTH    = FFT_WIDTH,
  parameter int unsigned CNT_W    = $clog2(N_POINTS)
) (
  input  logic                        clk_100,
  input  logic                        reset,
  input  logic [N_POINTS*2*WIDTH-1:0] in_frame,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic [2*WIDTH-1:0]          out_data,
  output logic [CNT_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_done
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rd_idx;
  logic [2*WIDTH-1:0] bins_q [N_POINTS];
  logic               frame_done_q;
  logic               cnt_last;
  logic               beat_fire;
  logic               load_fire;

`ifdef BIT_REVERSE_EN
  fft_bitrev_index #(
    .W(CNT_W)
  ) u_bitrev (
    .idx(cnt_q),
    .rev(rd_idx)
  );
`else
  assign rd_idx = cnt_q;
`endif

  // Handshake decode and output view of the buffer.
  always_comb begin
    cnt_last   = (cnt_q == CNT_W'(N_POINTS - 1));
    out_valid  = (state_q == StStream);
    out_last   = out_valid & cnt_last;
    out_index  = rd_idx;
    out_data   = bins_q[rd_idx];
    beat_fire  = out_valid & out_ready;
    // Accepting on the final beat lets the next frame follow with no gap.
    load_ready = (state_q == StIdle) | (beat_fire & out_last);
    load_fire  = load_valid & load_ready;
    frame_done = frame_done_q;
  end

  // Next state and beat counter; a load always restarts at bin 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_fire) begin
      state_d = StStream;
      cnt_d   = '0;
    end else if (beat_fire) begin
      if (cnt_last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control state; reset aborts any stream in flight.
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= beat_fire & out_last;
    end
  end

  // Frame buffer, written only when a load is accepted.
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(N_POINTS); k++) begin
        bins_q[k] <= '0;
      end
    end else if (load_fire) begin
      for (int k = 0; k < int'(N_POINTS); k++) begin
        bins_q[k] <= in_frame[k*2*WIDTH +: 2*WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer with a queue-based reference model.
module tb_fft_out_serializer;
  import fft_pkg::*;

  localparam int N  = FFT_N;
  localparam int W  = FFT_WIDTH;
  localparam int CW = $clog2(N);

  logic              clk_100 = 1'b0;
  logic              reset = 1'b0;
  logic [N*2*W-1:0]  in_frame = '0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [2*W-1:0]    out_data;
  logic [CW-1:0]     out_index;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              frame_done;

  fft_out_serializer dut (
    .clk_100   (clk_100),
    .reset     (reset),
    .in_frame  (in_frame),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done)
  );

  always #5 clk_100 = ~clk_100;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Natural bin number carried by beat i.
  function automatic int beat_bin(input int i);
    int r;
    r = i;
`ifdef BIT_REVERSE_EN
    r = 0;
    for (int b = 0; b < CW; b++) r = r * 2 + ((i >> b) & 1);
`endif
    return r;
  endfunction

  function automatic logic [2*W-1:0] frame_word(input int k);
    return in_frame[k*2*W +: 2*W];
  endfunction

  task automatic set_frame(input int kind);
    complex_t c;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0:       begin c.re = W'(k << FFT_FRAC); c.im = '0;       end
        1:       begin c.re = 16'h0080;          c.im = '0;       end
        2:       begin c.re = '0;                c.im = 16'h0080; end
        default: begin c.re = 16'hDEAD;          c.im = W'(k);    end
      endcase
      in_frame[k*2*W +: 2*W] = c;
    end
  endtask

  // Reference model: expected beats queued at each accepted load.
  logic [2*W-1:0] q_data[$];
  int             q_idx[$];
  bit             q_last[$];
  bit             fd_pending = 0;
  int             loads = 0;
  int             beats = 0;
  int             dones = 0;
  int             beat_in_frame = 0;
  logic [2*W-1:0] got[N];

  always @(negedge clk_100) begin
    bit exp_valid, exp_lr, beat, head_last;
    if (!reset) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      q_data.delete();
      q_idx.delete();
      q_last.delete();
      fd_pending    = 0;
      beat_in_frame = 0;
    end else begin
      exp_valid = (q_data.size() != 0);
      head_last = exp_valid ? q_last[0] : 1'b0;
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("frame_done", 64'(frame_done), 64'(fd_pending));
      if (exp_valid && out_valid) begin
        chk("out_data", 64'(out_data), 64'(q_data[0]));
        chk("out_index", 64'(out_index), 64'(q_idx[0]));
        chk("out_last", 64'(out_last), 64'(head_last));
      end
      if (frame_done) dones++;
      beat   = exp_valid && out_ready;
      exp_lr = !exp_valid || (beat && head_last);
      chk("load_ready", 64'(load_ready), 64'(exp_lr));
      fd_pending = beat && head_last;
      if (beat) begin
        got[beat_in_frame] = out_data;
        beat_in_frame = head_last ? 0 : beat_in_frame + 1;
        beats++;
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
        void'(q_last.pop_front());
      end
      if (load_valid && exp_lr) begin
        for (int j = 0; j < N; j++) begin
          q_data.push_back(frame_word(beat_bin(j)));
          q_idx.push_back(beat_bin(j));
          q_last.push_back(j == N - 1);
        end
        loads++;
      end
    end
  end

  task automatic do_load();
    int start;
    start = loads;
    load_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_100);
      #1;
      if (loads != start) break;
    end
    chk("load_accepted", 64'(loads - start), 64'd1);
    load_valid = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic drain(input int mode, input int exp_dones);
    int c;
    c = 0;
    while (dones < exp_dones && c < 500) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(posedge clk_100);
      #1;
      c++;
    end
    chk("drain_dones", 64'(dones), 64'(exp_dones));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, l0;
    // 1. Reset then a basic frame.
    repeat (3) @(posedge clk_100);
    #1;
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_index", 64'(out_index), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    reset = 1'b1;
    @(posedge clk_100);
    #1;
    chk("idle_load_ready", 64'(load_ready), 64'd1);
    set_frame(0);
    out_ready = 1'b1;
    b0 = beats;
    do_load();
    drain(0, 1);
    chk("t1_beats", 64'(beats - b0), 64'd32);
`ifdef BIT_REVERSE_EN
    chk("t1_beat1", 64'(got[1]), 64'h0800_0000);
    chk("t1_beat3", 64'(got[3]), 64'h0C00_0000);
`else
    chk("t1_beat1", 64'(got[1]), 64'h0080_0000);
    chk("t1_beat3", 64'(got[3]), 64'h0180_0000);
`endif
    chk("t1_beat31", 64'(got[31]), 64'h0F80_0000);
    chk("t1_load_ready", 64'(load_ready), 64'd1);

    // 2. Backpressure.
    out_ready = 1'b0;
    b0 = beats;
    do_load();
    drain(1, 2);
    chk("t2_beats", 64'(beats - b0), 64'd32);

    // 3. Back-to-back frames with load_valid held.
    out_ready = 1'b1;
    b0 = beats;
    set_frame(1);
    do_load();
    set_frame(2);
    do_load();
    drain(0, 4);
    chk("t3_beats", 64'(beats - b0), 64'd64);
    chk("t3_b_first", 64'(got[0]), 64'h0000_0080);

    // 4. Reset mid-stream.
    set_frame(0);
    do_load();
    for (int c = 0; c < 100 && beat_in_frame < 11; c++) begin
      @(posedge clk_100);
      #1;
    end
    chk("t4_beats_before_reset", 64'(beat_in_frame), 64'd11);
    #3;
    reset = 1'b0;
    #1;
    chk("t4_async_out_valid", 64'(out_valid), 64'd0);
    chk("t4_async_frame_done", 64'(frame_done), 64'd0);
    repeat (2) @(posedge clk_100);
    #1;
    reset = 1'b1;
    b0 = beats;
    do_load();
    drain(0, 5);
    chk("t4_beats_after", 64'(beats - b0), 64'd32);

    // 5. Load pulse during STREAM is ignored.
    set_frame(0);
    do_load();
    repeat (5) @(posedge clk_100);
    #1;
    l0 = loads;
    set_frame(3);
    load_valid = 1'b1;
    @(posedge clk_100);
    #1;
    load_valid = 1'b0;
    chk("t5_ignored_load", 64'(loads - l0), 64'd0);
    drain(0, 6);
`ifdef BIT_REVERSE_EN
    chk("t5_beat20", 64'(got[20]), 64'h0280_0000);
`else
    chk("t5_beat20", 64'(got[20]), 64'h0A00_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
Output-side unloader for the 32-point FFT/DFT datapath. It captures one frame of N_POINTS parallel complex bins from the DFT stage in a single cycle. It then streams the bins out one per cycle over a valid/ready interface to downstream logic (UART/DMA/debug capture). It is the consumer counterpart to the parallel-input feed that drives the DFT core.

Parameters:
N_POINTS, 32, bins per frame; power of two, minimum 2.
WIDTH, 16, bits per real/imag component, Q9.7 signed fixed point.
CNT_W, $clog2(N_POINTS), index/counter width; derived, not overridden.

Ports:
clk_100  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
in_frame  input  N_POINTS*2*WIDTH  flattened bins; bin k at [k*2W +: 2W]; within a bin, upper WIDTH = real, lower WIDTH = imag.
load_valid  input  1  in_frame holds a complete frame.
load_ready  output  1  block can accept a frame this cycle.
out_data  output  2*WIDTH  current bin, same real/imag packing.
out_index  output  CNT_W  bin number of out_data.
out_last  output  1  out_data is the final bin of the frame.
out_valid  output  1  out_data/out_index/out_last are valid.
out_ready  input  1  downstream accepts the beat.
frame_done  output  1  one-cycle pulse on acceptance of the last beat.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, buffer cleared to 0. Outputs: out_valid=0, out_data=0, out_index=0, out_last=0, frame_done=0. load_ready=1 once reset releases.
- States: IDLE, STREAM.
- load_ready (combinational) = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back frames with no bubble.
- Load fires on load_valid & load_ready:
  - All N_POINTS bins are registered.
  - cnt<=0, state<=STREAM.
  - out_valid=1 from the next cycle, with index 0. Latency is 1 clock.
- STREAM:
  - out_index = map(cnt); out_data = buf[map(cnt)]; out_last = (cnt==N_POINTS-1).
  - map is the identity unless the optional feature is compiled in.
  - Beat fires on out_valid & out_ready, then cnt<=cnt+1.
  - While out_valid & !out_ready: out_data, out_index and out_last hold stable. The buffer is not overwritten because load_ready=0.
- Last beat accepted:
  - frame_done pulses high in the following cycle.
  - If load fires in the same cycle: reload, cnt<=0, stay in STREAM; out_valid stays 1 with no gap.
  - Otherwise: state<=IDLE, out_valid<=0.
- cnt never wraps past N_POINTS-1. After the last beat it is forced to 0.
- load_valid while load_ready=0 is ignored. The upstream must hold the frame until accepted.
- Reset mid-frame: the stream is aborted immediately. A partially sent frame is discarded; no frame_done.
- No arithmetic on the data; bins pass bit-exact.

Optional Feature:
BIT_REVERSE_EN:
- Defined: map(cnt) = CNT_W-bit reversal of cnt. out_index reports the natural-order bin number, so a decimation-in-time core with bit-reversed output storage streams in natural frequency order. Example, N=32: beat 1 reads buf[16], out_index=16.
- Undefined: map is the identity; bins stream in buffer order; out_index=cnt.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_N=32, FFT_WIDTH=16, FFT_FRAC=7;
  - typedef complex_t {real, imag} packed;
  - function bitrev(idx, width).
- One natural sub-module: fft_bitrev_index, purely combinational CNT_W-bit reversal. It is instantiated only under BIT_REVERSE_EN.

Test Plan:
1. Basic frame: reset low 3 cycles then high; load bin k = {k*16'h0080, 16'h0000}; out_ready=1 → 32 consecutive beats, beat i = {i<<7, 0}, out_index=i, out_last only on beat 31, frame_done one cycle after beat 31, then load_ready=1.
2. Backpressure: same frame, out_ready toggles 1,0,0,1,... → no duplicated or skipped bins; out_data stable during every stall; exactly 32 accepted beats.
3. Back-to-back: frame A all bins 32'h0080_0000, frame B all 32'h0000_0080; load_valid held high → B loads on A's last beat, out_valid never drops, first B beat follows A's last directly.
4. Reset mid-stream: assert reset after beat 10 → out_valid=0 immediately (async), no frame_done; after release a new frame starts at index 0.
5. Ignored load: load_valid pulsed with a different frame during STREAM → the stream continues with the original data.
6. BIT_REVERSE_EN build: frame of case 1 → beat i carries out_index=bitrev5(i) and data {bitrev5(i)<<7, 0}; e.g. beat 3 → index 24, data 32'h0C00_0000.
